// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} and stalls execute until done.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_req
);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   rem_q;
    logic               sign_q_q;
    logic               sign_r_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   quot_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quot_fin;
    logic [WIDTH-1:0]   rem_fin;

    assign op1_abs = (div_signed && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign op2_abs = (div_signed && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

    // Partial remainder needs one extra bit before the compare.
    assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, dvs_q};
    assign ge       = rem_sh >= {1'b0, dvs_q};
    assign quot_d   = {dvd_q[WIDTH-2:0], ge};
    assign rem_d    = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quot_fin = sign_q_q ? -quot_d : quot_d;
    assign rem_fin  = sign_r_q ? -rem_d : rem_d;

    assign result    = result_q;
    assign ready     = ready_q;
    assign stall_req = div_start & ~ready_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (div_start && !annul) begin
                        if (opdata2 == '0) begin
                            state_q <= BYZERO;
                        end else begin
                            state_q  <= ON;
                            dvd_q    <= op1_abs;
                            dvs_q    <= op2_abs;
                            rem_q    <= '0;
                            cnt_q    <= '0;
                            sign_q_q <= div_signed &
                                        (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                            sign_r_q <= div_signed & opdata1[WIDTH-1];
                        end
                    end
                end
                BYZERO: begin
                    if (annul) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end else begin
                        result_q <= '0;
                        ready_q  <= 1'b1;
                        state_q  <= END;
                    end
                end
                ON: begin
                    if (annul) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end else begin
                        dvd_q <= quot_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            result_q <= {rem_fin, quot_fin};
                            ready_q  <= 1'b1;
                            state_q  <= END;
                        end
                    end
                end
                END: begin
                    if (annul || !div_start) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit against an arithmetic reference model.
// Directed cases, randomized operands, annul and async reset checks.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_req;

    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    logic [63:0] last_res = '0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .div_start (div_start),
        .div_signed(div_signed),
        .opdata1   (opdata1),
        .opdata2   (opdata2),
        .annul     (annul),
        .result    (result),
        .ready     (ready),
        .stall_req (stall_req)
    );

    task automatic check(input string tag, input logic [95:0] obs,
                         input logic [95:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // C-style division: truncate toward zero, remainder follows dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_div(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic s);
        logic [63:0] exp;
        int          lat;
        bit          stall_ok;
        bit          hold_ok;
        exp = ref_div(a, b, s);
        @(negedge clk);
        div_start  = 1'b1;
        div_signed = s;
        opdata1    = a;
        opdata2    = b;
        annul      = 1'b0;
        #1 stall_ok = (stall_req === 1'b1);
        @(posedge clk);
        #1;
        opdata1    = $urandom;
        opdata2    = $urandom;
        div_signed = ~s;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (ready === 1'b1) break;
            if (stall_req !== 1'b1) stall_ok = 1'b0;
        end
        if (b == 32'd0)
            check({tag, " lat"}, 96'(lat >= 1 && lat <= 2), 96'd1);
        else
            check({tag, " lat"}, 96'(lat), 96'd32);
        check({tag, " res"}, 96'(result), 96'(exp));
        check({tag, " stall"}, 96'(stall_ok), 96'd1);
        hold_ok = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b1 || result !== exp || stall_req !== 1'b0)
                hold_ok = 1'b0;
        end
        check({tag, " hold"}, 96'(hold_ok), 96'd1);
        @(negedge clk);
        div_start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " drop"}, 96'({ready, result}), 96'({1'b0, exp}));
        last_res = exp;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        bit          seen;
        resetn     = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        annul      = 1'b0;
        #1;
        check("reset", 96'({ready, result}), 96'd0);
        #20;
        @(negedge clk);
        resetn = 1'b1;

        run_div("u100_7", 32'd100, 32'd7, 1'b0);
        run_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_div("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_div("byzero", 32'h1234, 32'd0, 1'b1);
        run_div("ovf_s", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_div("ovf_u", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Annul partway through ON.
        @(negedge clk);
        div_start  = 1'b1;
        div_signed = 1'b0;
        opdata1    = 32'd12345;
        opdata2    = 32'd67;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul     = 1'b0;
        div_start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) seen = 1'b1;
        end
        check("annul ready", 96'(seen), 96'd0);
        check("annul res", 96'(result), 96'(last_res));
        run_div("post_annul", 32'd12345, 32'd67, 1'b0);

        // Asynchronous reset mid-ON.
        @(negedge clk);
        div_start  = 1'b1;
        div_signed = 1'b1;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async rst", 96'({ready, result}), 96'd0);
        @(negedge clk);
        div_start = 1'b0;
        resetn    = 1'b1;
        run_div("post_rst", 32'd1000, 32'd3, 1'b1);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9))
                                             : $urandom;
            rs = 1'($urandom_range(0, 1));
            run_div($sformatf("rnd%0d", i), ra, rb, rs);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
